// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressed word store answering one request at a
// time after a fixed LATENCY, with a one-cycle mem_ready completion pulse.
module data_mem_responder #(
  parameter int unsigned MEM_WORDS = 2048,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int unsigned ADDR_BITS = $clog2(MEM_WORDS);
  localparam logic [3:0]  CntInit   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] addr_q;
  logic        we_q;
  logic [7:0]  wdata_q [0:3];
  logic        err_q;
  logic        capture;
  logic        access;
  logic        in_range;
  logic [ADDR_BITS-1:0] word_idx;

  // Byte k of a word lives at byte address base+k; storage is never reset.
  logic [7:0] mem_q [MEM_WORDS][0:3];

  // Alignment bits are dropped: every access is word aligned down.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  assign in_range = (addr_q >> ADDR_BITS) == '0;
  assign word_idx = addr_q[ADDR_BITS+1:2];

  // Next-state logic: accept in IDLE/RESP, count down in BUSY, access at cnt==0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          capture = 1'b1;
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (mem_req) begin
          capture = 1'b1;
          cnt_d   = CntInit;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, captured request and read-data register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        wdata_q[k]      <= 8'h00;
        mem_data_out[k] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q <= mem_addr[31:2];
        we_q   <= mem_write_en;
        for (int k = 0; k < 4; k++) wdata_q[k] <= mem_data_in[k];
      end
      if (access) begin
        err_q <= !in_range;
        if (!we_q) begin
          for (int k = 0; k < 4; k++) begin
            mem_data_out[k] <= in_range ? mem_q[word_idx][k] : 8'h00;
          end
        end
      end
    end
  end

  // Storage write; access is only raised from BUSY, which reset leaves.
  always_ff @(posedge clk) begin
    if (access && we_q && in_range) begin
      for (int k = 0; k < 4; k++) mem_q[word_idx][k] <= wdata_q[k];
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    mem_busy  = (state_q == StBusy);
    mem_ready = (state_q == StResp);
    mem_err   = mem_ready && err_q;
  end

endmodule
